// File: rtl/sparc_ifu_wrrarb.sv
// rtl/sparc_ifu_wrrarb.sv - weighted round-robin arbiter with hold, test override and scan-chained state
module sparc_ifu_wrrarb #(
  parameter int NREQ  = 4,
  parameter int WT_W  = 2,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   se,
  input  logic                   si,
  output logic                   so,
  input  logic [NREQ-1:0]        req_vec,
  input  logic [NREQ*WT_W-1:0]   wt_vec,
  input  logic                   advance,
  input  logic                   hold,
  input  logic                   rst_tri_enable,
  output logic [NREQ-1:0]        grant_vec,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_vld
);

  localparam int CHAIN_W = NREQ + WT_W;

  logic [NREQ-1:0] last_vec;
  logic [WT_W-1:0] burst_cnt;

  int              owner_i;
  logic            owner_req;
  logic [WT_W-1:0] owner_wt;
  logic [WT_W-1:0] eff_wt;
  logic            stay;
  logic [NREQ-1:0] rot_vec;
  logic            rot_found;
  logic            upd;
  logic            to_owner;
  logic [CHAIN_W-1:0] chain;

  always_comb begin
    owner_i   = 0;
    owner_req = 1'b0;
    owner_wt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (last_vec[i]) begin
        owner_i   = i;
        owner_req = req_vec[i];
        owner_wt  = wt_vec[i*WT_W +: WT_W];
      end
    end
  end

  // A zero weight still entitles the owner to one grant.
  assign eff_wt = (owner_wt == '0) ? WT_W'(1) : owner_wt;
  assign stay   = owner_req &&
                  (({1'b0, burst_cnt} + (WT_W+1)'(1)) < {1'b0, eff_wt});

  // Search starts just past the owner and reaches the owner itself last.
  always_comb begin
    rot_vec   = '0;
    rot_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = owner_i + k;
      if (j >= NREQ) j = j - NREQ;
      if (!rot_found && req_vec[j]) begin
        rot_vec[j] = 1'b1;
        rot_found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (rst_tri_enable)
      grant_vec = NREQ'(1);
    else if (owner_req && (hold || stay))
      grant_vec = last_vec;
    else
      grant_vec = rot_vec;
  end

  always_comb begin
    gnt_idx = '0;
    if (!rst_tri_enable) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_vec[i]) gnt_idx = IDX_W'(i);
      end
    end
  end

  assign gnt_vld  = (|grant_vec) && !rst_tri_enable;
  assign upd      = advance && gnt_vld;
  assign to_owner = (grant_vec == last_vec);

  assign chain = {last_vec, burst_cnt};
  assign so    = chain[CHAIN_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      last_vec  <= NREQ'(1);
      burst_cnt <= '0;
    end else if (se) begin
      {last_vec, burst_cnt} <= {chain[CHAIN_W-2:0], si};
    end else if (upd) begin
      last_vec <= grant_vec;
      // Grants taken under hold do not use up the owner's weight.
      if (!to_owner)
        burst_cnt <= '0;
      else if (!hold)
        burst_cnt <= burst_cnt + WT_W'(1);
    end
  end

endmodule

// File: tb/tb_sparc_ifu_wrrarb.sv
// tb/tb_sparc_ifu_wrrarb.sv - scoreboard bench for sparc_ifu_wrrarb, 4-way and 8-way instances
module tb_sparc_ifu_wrrarb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        se = 1'b0;
  logic        si = 1'b0;
  logic        advance = 1'b0;
  logic        hold = 1'b0;
  logic        rte = 1'b0;
  logic [3:0]  req4 = '0;
  logic [7:0]  wt4 = 8'h55;
  logic [7:0]  req8 = '0;
  logic [23:0] wt8 = 24'o11111111;
  logic        so4, so8;
  logic [3:0]  grant4;
  logic [1:0]  idx4;
  logic        vld4;
  logic [7:0]  grant8;
  logic [2:0]  idx8;
  logic        vld8;

  always #5 clk = ~clk;

  sparc_ifu_wrrarb #(.NREQ(4), .WT_W(2), .IDX_W(2)) dut4 (
    .clk(clk), .reset(reset), .se(se), .si(si), .so(so4),
    .req_vec(req4), .wt_vec(wt4), .advance(advance), .hold(hold),
    .rst_tri_enable(rte), .grant_vec(grant4), .gnt_idx(idx4), .gnt_vld(vld4)
  );

  sparc_ifu_wrrarb #(.NREQ(8), .WT_W(3), .IDX_W(3)) dut8 (
    .clk(clk), .reset(reset), .se(se), .si(si), .so(so8),
    .req_vec(req8), .wt_vec(wt8), .advance(advance), .hold(hold),
    .rst_tri_enable(rte), .grant_vec(grant8), .gnt_idx(idx8), .gnt_vld(vld8)
  );

  typedef struct {
    int         inst;
    logic [7:0] g;
    logic [2:0] idx;
    logic       vld;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [7:0]  WA1 = 8'b01_01_01_01;
  localparam logic [7:0]  WAW = 8'b01_01_11_01;
  localparam logic [7:0]  WAH = 8'b01_10_01_01;
  localparam logic [23:0] WB1 = 24'o11111111;
  localparam logic [23:0] WB7 = 24'o51111110;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] ag;
      logic [2:0] ai;
      logic       av;
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        ag = {4'b0, grant4};
        ai = {1'b0, idx4};
        av = vld4;
      end else begin
        ag = grant8;
        ai = idx8;
        av = vld8;
      end
      check({e.name, ".grant"}, ag, e.g);
      check({e.name, ".idx"}, {5'b0, ai}, {5'b0, e.idx});
      check({e.name, ".vld"}, {7'b0, av}, {7'b0, e.vld});
    end
  end

  task automatic cyc(input int inst, input logic r, input logic a, input logic h,
                     input logic t, input logic [7:0] rq, input logic [23:0] wt,
                     input logic [7:0] eg, input logic [2:0] ei, input logic ev,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = r;
    advance = a;
    hold    = h;
    rte     = t;
    if (inst == 0) begin
      req4 = rq[3:0];
      wt4  = wt[7:0];
      req8 = '0;
    end else begin
      req8 = rq;
      wt8  = wt;
      req4 = '0;
    end
    e.inst = inst; e.g = eg; e.idx = ei; e.vld = ev; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    // reset cycle: outputs still follow the reset-value state
    cyc(0, 1, 1, 0, 0, 8'hF, WA1, 8'h2, 3'd1, 1, "rst_out");
    cyc(0, 0, 1, 0, 0, 8'hF, WA1, 8'h2, 3'd1, 1, "fair0");
    cyc(0, 0, 1, 0, 0, 8'hF, WA1, 8'h4, 3'd2, 1, "fair1");
    cyc(0, 0, 1, 0, 0, 8'hF, WA1, 8'h8, 3'd3, 1, "fair2");
    cyc(0, 0, 1, 0, 0, 8'hF, WA1, 8'h1, 3'd0, 1, "fair3");
    cyc(0, 0, 1, 0, 0, 8'hF, WA1, 8'h2, 3'd1, 1, "fair4");
    cyc(0, 1, 1, 0, 0, 8'hF, WA1, 8'h4, 3'd2, 1, "rst_prio");

    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "wt0");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "wt1");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "wt2");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h4, 3'd2, 1, "wt3");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h8, 3'd3, 1, "wt4");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h1, 3'd0, 1, "wt5");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "wt6");

    cyc(0, 0, 1, 0, 0, 8'hF, WA1, 8'h4, 3'd2, 1, "to_owner2");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, 0, 8'h0, WA1, 8'h0, 3'd0, 0, "idle");
    cyc(0, 0, 0, 0, 0, 8'h3, WA1, 8'h1, 3'd0, 1, "idle_resume");

    for (int i = 0; i < 5; i++)
      cyc(0, 0, 1, 1, 0, 8'hF, WAH, 8'h4, 3'd2, 1, "hold");
    cyc(0, 0, 1, 0, 0, 8'hF, WAH, 8'h4, 3'd2, 1, "hold_release");
    cyc(0, 0, 1, 0, 0, 8'hF, WAH, 8'h8, 3'd3, 1, "hold_rotate");

    cyc(0, 0, 1, 0, 1, 8'h8, WA1, 8'h1, 3'd0, 0, "tri0");
    cyc(0, 0, 1, 0, 1, 8'h8, WA1, 8'h1, 3'd0, 0, "tri1");
    cyc(0, 0, 0, 0, 0, 8'h9, WA1, 8'h1, 3'd0, 1, "tri_resume");
    cyc(0, 0, 1, 1, 0, 8'h7, WA1, 8'h1, 3'd0, 1, "hold_ignored");

    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "mid0");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "mid1");
    cyc(0, 1, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "rst_mid");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "post_rst0");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "post_rst1");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h2, 3'd1, 1, "post_rst2");
    cyc(0, 0, 1, 0, 0, 8'hF, WAW, 8'h4, 3'd2, 1, "post_rst3");

    // 8-way instance has seen no requests so far and is still in reset state
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] g;
      g = 8'h1 << (i % 8);
      cyc(1, 0, 1, 0, 0, 8'hFF, WB1, g, 3'(i % 8), 1, "wrap8");
    end
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 1, 0, 0, 8'h81, WB7, 8'h80, 3'd7, 1, "burst8");
    cyc(1, 0, 1, 0, 0, 8'h81, WB7, 8'h01, 3'd0, 1, "burst8_end");
    cyc(1, 0, 1, 0, 0, 8'h81, WB7, 8'h80, 3'd7, 1, "zero_wt");

    @(posedge clk);
    #1;
    advance = 1'b0;
    req4 = '0;
    req8 = '0;
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
